// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds FSM state, the control bundle and its NOP value.
package pipe_ctrl_pkg;

  localparam int DEF_REG_W = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP       = ctrl_t'(7'b0000000);
  localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(7'b1101011);
  localparam ctrl_t CTRL_BRANCH    = ctrl_t'(7'b0010100);
  localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(7'b1100100);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle.
// master drives pipeline status, slave returns stage controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_use_rs1;
  logic             ifid_use_rs2;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             ex_branch_taken;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic             exmem_hold;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output idex_memread, idex_rd,
    output ifid_rs1, ifid_rs2,
    output ifid_use_rs1, ifid_use_rs2,
    output exmem_memread, exmem_memwrite,
    output ex_branch_taken, dmem_ready,
    input  dmem_req, pc_hold,
    input  ifid_hold, ifid_flush,
    input  idex_hold, idex_bubble,
    input  exmem_hold, memwb_bubble,
    input  mem_err, stall_cnt
  );

  modport slave (
    input  idex_memread, idex_rd,
    input  ifid_rs1, ifid_rs2,
    input  ifid_use_rs1, ifid_use_rs2,
    input  exmem_memread, exmem_memwrite,
    input  ex_branch_taken, dmem_ready,
    output dmem_req, pc_hold,
    output ifid_hold, ifid_flush,
    output idex_hold, idex_bubble,
    output exmem_hold, memwb_bubble,
    output mem_err, stall_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detect between ID/EX and IF/ID.
// x0 destinations never create a dependency.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             memread,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = use_rs1 & (rd == rs1);
  assign hit2 = use_rs2 & (rd == rs2);

  assign load_use = memread
                  & (rd != '0)
                  & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Priority: memory stall > taken branch > load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16,
  parameter int REG_W       = DEF_REG_W
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WC_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WC_W-1:0]  wcnt_q;
  logic [WC_W-1:0]  wcnt_inc;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic  mem_op;
  logic  rdy;
  logic  timeout;
  logic  mem_stall;
  logic  load_use;
  logic  br_go;
  logic  lu_go;
  logic  req;
  ctrl_t ctrl;

  assign mem_op   = bus.exmem_memread | bus.exmem_memwrite;
  assign rdy      = bus.dmem_ready;
  assign wcnt_inc = wcnt_q + 1'b1;

  // Abandon when the wait count is about to hit its last value.
  assign timeout = (state_q == MEM_WAIT)
                 & ~rdy
                 & (wcnt_inc == WC_LAST);

  load_use_detect #(
    .REG_W    (REG_W)
  ) u_lud (
    .memread  (bus.idex_memread),
    .rd       (bus.idex_rd),
    .rs1      (bus.ifid_rs1),
    .rs2      (bus.ifid_rs2),
    .use_rs1  (bus.ifid_use_rs1),
    .use_rs2  (bus.ifid_use_rs2),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op & ~rdy) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (rdy | timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        req       = mem_op;
        mem_stall = mem_op & ~rdy;
      end
      MEM_WAIT: begin
        req       = 1'b1;
        mem_stall = ~rdy & ~timeout;
      end
      default: begin
        req       = 1'b0;
        mem_stall = 1'b0;
      end
    endcase
  end

  assign br_go = bus.ex_branch_taken & ~mem_stall;
  assign lu_go = load_use & ~mem_stall & ~bus.ex_branch_taken;

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      mem_stall: ctrl = CTRL_MEM_STALL;
      br_go:     ctrl = CTRL_BRANCH;
      lu_go:     ctrl = CTRL_LOAD_USE;
      default:   ctrl = CTRL_NOP;
    endcase
    // Reset forces the idle decode regardless of pipeline inputs.
    if (!rst) ctrl = CTRL_NOP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else if (state_q == IDLE) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (ctrl.pc_hold & ~&cnt_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.dmem_req     = req & rst;
  assign bus.pc_hold      = ctrl.pc_hold;
  assign bus.ifid_hold    = ctrl.ifid_hold;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_hold    = ctrl.idex_hold;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.exmem_hold   = ctrl.exmem_hold;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.mem_err      = err_q;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Expected controls are queued per cycle and checked mid-cycle.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(
    .TIMEOUT_CYC (16),
    .CNT_W       (16),
    .REG_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {req,pc_hold,ifid_hold,ifid_flush,idex_hold,idex_bubble,exmem_hold,memwb_bubble}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b0110_0100;
  localparam logic [7:0] O_MST  = 8'b1110_1011;
  localparam logic [7:0] O_REQ  = 8'b1000_0000;
  localparam logic [7:0] O_BR   = 8'b0001_0100;
  localparam logic [7:0] O_BRQ  = 8'b1001_0100;

  typedef struct packed {
    logic [7:0]  o;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {bus.dmem_req, bus.pc_hold, bus.ifid_hold,
            bus.ifid_flush, bus.idex_hold, bus.idex_bubble,
            bus.exmem_hold, bus.memwb_bubble};
  endfunction

  task automatic cyc(string tag, logic [7:0] o,
                     logic err, int cnt);
    exp_t e;
    e.o   = o;
    e.err = err;
    e.cnt = cnt[15:0];
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".ctl"}, 32'(obs()), 32'(e.o));
    check({tag, ".err"}, 32'(bus.mem_err), 32'(e.err));
    check({tag, ".cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic mem(logic rd, logic wr, logic rdy);
    bus.exmem_memread  = rd;
    bus.exmem_memwrite = wr;
    bus.dmem_ready     = rdy;
  endtask

  task automatic lu(logic mr, logic [4:0] rd, logic [4:0] r1,
                    logic [4:0] r2, logic u1, logic u2);
    bus.idex_memread = mr;
    bus.idex_rd      = rd;
    bus.ifid_rs1     = r1;
    bus.ifid_rs2     = r2;
    bus.ifid_use_rs1 = u1;
    bus.ifid_use_rs2 = u2;
  endtask

  initial begin
    rst = 1'b0;
    mem(1'b1, 1'b0, 1'b0);
    lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b1;
    cyc("rst_a", O_NONE, 1'b0, 0);
    cyc("rst_b", O_NONE, 1'b0, 0);

    rst = 1'b1;
    mem(1'b0, 1'b0, 1'b0);
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b0;
    cyc("idle", O_NONE, 1'b0, 0);

    lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc("lu_rs1", O_LU, 1'b0, 0);
    lu(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc("lu_rs1_done", O_NONE, 1'b0, 1);
    lu(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
    cyc("lu_rs2", O_LU, 1'b0, 1);
    lu(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
    cyc("lu_nouse", O_NONE, 1'b0, 2);
    lu(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cyc("lu_x0", O_NONE, 1'b0, 2);
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("lu_x0_done", O_NONE, 1'b0, 2);

    mem(1'b1, 1'b0, 1'b0);
    cyc("mw1", O_MST, 1'b0, 2);
    cyc("mw2", O_MST, 1'b0, 3);
    cyc("mw3", O_MST, 1'b0, 4);
    mem(1'b1, 1'b0, 1'b1);
    cyc("mw_rdy", O_REQ, 1'b0, 5);
    mem(1'b0, 1'b0, 1'b0);
    cyc("mw_done", O_NONE, 1'b0, 5);
    mem(1'b0, 1'b1, 1'b1);
    cyc("st_zero", O_REQ, 1'b0, 5);
    mem(1'b0, 1'b0, 1'b0);
    cyc("st_done", O_NONE, 1'b0, 5);

    mem(1'b1, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    cyc("br_st1", O_MST, 1'b0, 5);
    cyc("br_st2", O_MST, 1'b0, 6);
    mem(1'b1, 1'b0, 1'b1);
    cyc("br_flush", O_BRQ, 1'b0, 7);
    mem(1'b0, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b0;
    cyc("br_done", O_NONE, 1'b0, 7);
    bus.ex_branch_taken = 1'b1;
    lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc("br_over_lu", O_BR, 1'b0, 7);
    bus.ex_branch_taken = 1'b0;
    lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("br_lu_done", O_NONE, 1'b0, 7);

    mem(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc("tmo_stall", O_MST, 1'b0, 7 + i);
    end
    cyc("tmo_end", O_REQ, 1'b0, 22);
    mem(1'b0, 1'b0, 1'b0);
    cyc("tmo_err", O_NONE, 1'b1, 22);
    cyc("tmo_sticky", O_NONE, 1'b1, 22);

    mem(1'b1, 1'b0, 1'b0);
    cyc("rw_enter", O_MST, 1'b1, 22);
    rst = 1'b0;
    cyc("rw_rst", O_NONE, 1'b0, 0);
    rst = 1'b1;
    mem(1'b0, 1'b0, 1'b0);
    cyc("rw_idle", O_NONE, 1'b0, 0);
    mem(1'b1, 1'b0, 1'b1);
    cyc("rw_fresh", O_REQ, 1'b0, 0);
    mem(1'b0, 1'b0, 1'b0);
    cyc("rw_end", O_NONE, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
